// File: rtl/gcd_pkg.sv
// Shared constants and FSM state encoding for the subtractive GCD controller.
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_seq_ctrl_if.sv
// Operand/result handshake bundle between producer, controller and consumer.
interface gcd_seq_ctrl_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] steps_out;
    logic             err_zero;

    // master drives operands and accepts results; slave is the controller
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, steps_out, err_zero
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, steps_out, err_zero
    );
endinterface

// File: rtl/gcd_step.sv
// One subtractive GCD step: the larger operand is reduced by the smaller one.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             eq
);
    assign eq     = (a == b);
    assign a_next = (a > b) ? (a - b) : a;
    assign b_next = (b > a) ? (b - a) : b;
endmodule

// File: rtl/gcd_seq_ctrl.sv
// Multi-cycle GCD sequencer: accepts an operand pair, runs one subtract per
// clock until the operands meet, then holds the result until consumed.
module gcd_seq_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    gcd_seq_ctrl_if.slave bus
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] gcd_reg, gcd_next;
    logic [CNT_W-1:0] steps_reg, steps_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic             step_eq;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .b      (b_reg),
        .a_next (step_a),
        .b_next (step_b),
        .eq     (step_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            gcd_reg   <= '0;
            steps_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            gcd_reg   <= gcd_next;
            steps_reg <= steps_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        gcd_next   = gcd_reg;
        steps_next = steps_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.a_in;
                    b_next     = bus.b_in;
                    cnt_next   = '0;
                    steps_next = '0;
                    err_next   = 1'b0;
                    // zero operands short-circuit straight to the result
                    if (bus.a_in == '0 && bus.b_in == '0) begin
                        gcd_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else if (bus.a_in == '0) begin
                        gcd_next   = bus.b_in;
                        state_next = DONE;
                    end else if (bus.b_in == '0) begin
                        gcd_next   = bus.a_in;
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (step_eq) begin
                    gcd_next   = a_reg;
                    steps_next = cnt_reg;
                    state_next = DONE;
                end else begin
                    a_next   = step_a;
                    b_next   = step_b;
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.gcd_out   = gcd_reg;
    assign bus.steps_out = steps_reg;
    assign bus.err_zero  = err_reg;
endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Scoreboard bench for gcd_seq_ctrl: directed latency/backpressure/reset cases
// followed by a back-to-back random stream checked against a reference model.
module tb_gcd_seq_ctrl;
    localparam int W = 7;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] s;
        logic         e;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    gcd_seq_ctrl_if #(.WIDTH(W), .CNT_W(W)) ifc ();

    gcd_seq_ctrl #(.WIDTH(W), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int   x, y, n;
        r.e = 1'b0;
        r.s = '0;
        r.lat = 1;
        if (a == 0 && b == 0) begin
            r.g = '0;
            r.e = 1'b1;
        end else if (a == 0) begin
            r.g = b;
        end else if (b == 0) begin
            r.g = a;
        end else begin
            x = a; y = b; n = 0;
            while (x != y) begin
                if (x > y) x = x - y; else y = y - x;
                n++;
            end
            r.g = x[W-1:0];
            r.s = (n > 127) ? 7'd127 : n[W-1:0];
            r.lat = n + 2;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.a_in = '0; ifc.b_in = '0; ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.gcd_out !== '0 ||
            ifc.steps_out !== '0 || ifc.err_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b gcd=%0d steps=%0d err=%b, want 1 0 0 0 0",
                     ifc.in_ready, ifc.out_valid, ifc.gcd_out, ifc.steps_out, ifc.err_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset done");
    endtask

    // one transaction; bp = cycles of out_ready low after out_valid rises
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        exp_t         ex;
        int           lat;
        logic [W-1:0] g0, s0;
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.a_in = a; ifc.b_in = b;
        ifc.out_ready = (bp == 0);
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 1;
        while (!ifc.out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        ex = sb.pop_front();
        checks++;
        if (ifc.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout (%0d,%0d): out_valid never rose within %0d cycles", a, b, lat);
            ifc.out_ready = 1'b1;
            return;
        end
        checks++;
        if (ifc.gcd_out !== ex.g || ifc.steps_out !== ex.s || ifc.err_zero !== ex.e || lat != ex.lat) begin
            errors++;
            $display("FAIL result (%0d,%0d): gcd=%0d steps=%0d err=%b lat=%0d, want gcd=%0d steps=%0d err=%b lat=%0d",
                     a, b, ifc.gcd_out, ifc.steps_out, ifc.err_zero, lat, ex.g, ex.s, ex.e, ex.lat);
        end
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_done (%0d,%0d): in_ready=%b, want 0", a, b, ifc.in_ready);
        end
        g0 = ifc.gcd_out; s0 = ifc.steps_out;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.gcd_out !== g0 || ifc.steps_out !== s0) begin
                errors++;
                $display("FAIL hold cycle %0d: out_valid=%b in_ready=%b gcd=%0d steps=%0d, want 1 0 %0d %0d",
                         i, ifc.out_valid, ifc.in_ready, ifc.gcd_out, ifc.steps_out, g0, s0);
            end
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release (%0d,%0d): out_valid=%b in_ready=%b, want 0 1",
                     a, b, ifc.out_valid, ifc.in_ready);
        end
        $display("txn a=%0d b=%0d gcd=%0d steps=%0d err=%b lat=%0d bp=%0d",
                 a, b, g0, s0, ex.e, lat, bp);
    endtask

    task automatic test_directed();
        do_txn(7'd12, 7'd18, 0);
        do_txn(7'd127, 7'd1, 0);
        do_txn(7'd45, 7'd45, 0);
        do_txn(7'd0, 7'd9, 0);
        do_txn(7'd0, 7'd0, 0);
        do_txn(7'd30, 7'd0, 0);
    endtask

    task automatic test_backpressure();
        do_txn(7'd84, 7'd36, 5);
    endtask

    task automatic test_reset_inflight();
        bit seen = 0;
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.a_in = 7'd100; ifc.b_in = 7'd3; ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.gcd_out !== '0 ||
            ifc.steps_out !== '0 || ifc.err_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight: in_ready=%b out_valid=%b gcd=%0d steps=%0d err=%b, want 1 0 0 0 0",
                     ifc.in_ready, ifc.out_valid, ifc.gcd_out, ifc.steps_out, ifc.err_zero);
        end
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL discarded_result: out_valid=1 seen after reset, want 0");
        end
        $display("reset in flight (100,3) discarded");
        do_txn(7'd21, 7'd14, 0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [W-1:0] pa[N];
        logic [W-1:0] pb[N];
        int   idx = 0, got = 0, cyc = 0;
        bit   acc;
        exp_t ex;
        pa[0] = 0;   pb[0] = 0;
        pa[1] = 127; pb[1] = 0;
        pa[2] = 0;   pb[2] = 127;
        pa[3] = 127; pb[3] = 127;
        pa[4] = 127; pb[4] = 1;
        pa[5] = 1;   pb[5] = 127;
        for (int i = 6; i < N; i++) begin
            pa[i] = 7'($urandom_range(0, 127));
            pb[i] = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1; ifc.a_in = pa[0]; ifc.b_in = pb[0];
        while (got < N && cyc < 10000) begin
            @(negedge clk);
            acc = ifc.in_ready && ifc.in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sb.push_back(model(pa[idx], pb[idx]));
                idx++;
                if (idx < N) begin
                    ifc.a_in = pa[idx]; ifc.b_in = pb[idx];
                end else begin
                    ifc.in_valid = 1'b0;
                end
            end
            if (ifc.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected result gcd=%0d with empty scoreboard", ifc.gcd_out);
                end else begin
                    ex = sb.pop_front();
                    if (ifc.gcd_out !== ex.g || ifc.steps_out !== ex.s || ifc.err_zero !== ex.e) begin
                        errors++;
                        $display("FAIL b2b[%0d] (%0d,%0d): gcd=%0d steps=%0d err=%b, want %0d %0d %b",
                                 got, pa[got], pb[got], ifc.gcd_out, ifc.steps_out, ifc.err_zero, ex.g, ex.s, ex.e);
                    end
                    $display("b2b[%0d] a=%0d b=%0d gcd=%0d steps=%0d err=%b",
                             got, pa[got], pb[got], ifc.gcd_out, ifc.steps_out, ifc.err_zero);
                end
                got++;
            end
        end
        ifc.in_valid = 1'b0;
        checks++;
        if (got != N || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: results=%0d pending=%0d, want %0d 0", got, sb.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_inflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
